mem_arbiter: RTL

Two-port round-robin arbiter sharing the single-port 1024x16 `memory` between the instruction-fetch path (port 0) and the load/store path (port 1). It accepts held-level requests, serialises them into one memory access at a time, drives `address`/`WE`/`writeData`, and returns captured read data with a one-cycle acknowledge. It sits between the CPU control/datapath and `memory`.

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// Port 0 is instruction fetch, port 1 is load/store; one access per three cycles.
module mem_arbiter #(
  parameter int N = 10,
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] addr1,
  input  logic [M-1:0] wdata0,
  input  logic [M-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic [M-1:0] rdata0,
  output logic [M-1:0] rdata1,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [M-1:0] mem_wdata,
  input  logic [M-1:0] mem_rdata,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e       state_q, state_d;
  logic         grant_q, grant_d;
  logic         last_q, last_d;
  logic         mem_we_q, mem_we_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic [M-1:0] mem_wdata_q, mem_wdata_d;
  logic [M-1:0] rdata0_q, rdata0_d;
  logic [M-1:0] rdata1_q, rdata1_d;
  logic         pick;

  // Under contention the port that was not served last wins.
  assign pick = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d     = pick;
          last_d      = pick;
          mem_addr_d  = pick ? addr1  : addr0;
          mem_we_d    = pick ? we1    : we0;
          mem_wdata_d = pick ? wdata1 : wdata0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (!mem_we_q) begin
          if (grant_q) rdata1_d = mem_rdata;
          else         rdata0_d = mem_rdata;
        end
        mem_we_d = 1'b0;
        state_d  = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack0 = (state_q == RESP) && !grant_q;
    ack1 = (state_q == RESP) &&  grant_q;
    busy = (state_q != IDLE);
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule
